// File: rtl/vga_scaled_out_pkg.sv
// ppu_defines: shared definitions for the PPU VGA output stage.
//   vga_h_state_t / vga_v_state_t : horizontal / vertical timing phases
//   DEF_*                         : default timing (341 x 524, 1x / 2x scale)
//   rgb_t, BLACK                  : 24-bit colour word and its zero value
package ppu_defines;

  typedef enum logic [2:0] {H_VIS, H_FP, H_SYNC, H_BP, H_IDLE} vga_h_state_t;
  typedef enum logic [2:0] {V_PRE, V_VIS, V_FP, V_SYNC, V_BP}  vga_v_state_t;

  localparam int unsigned DEF_H_VIS   = 256;
  localparam int unsigned DEF_H_FP    = 8;
  localparam int unsigned DEF_H_SYNC  = 40;
  localparam int unsigned DEF_H_BP    = 20;
  localparam int unsigned DEF_H_IDLE  = 17;
  localparam int unsigned DEF_V_PRE   = 4;
  localparam int unsigned DEF_V_VIS   = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 28;
  localparam int unsigned DEF_H_SCALE = 1;
  localparam int unsigned DEF_V_SCALE = 2;

  typedef logic [23:0] rgb_t;
  localparam rgb_t BLACK = '0;

endpackage

// File: rtl/vga_scaled_out_palette.sv
// nes_palette: combinational NES 6-bit colour index to 24-bit RGB lookup.
//   idx : NES palette index
//   rgb : {r, g, b}, 8 bits each; unused entries are black
module nes_palette (
  input  logic [5:0]  idx,
  output logic [23:0] rgb
);
  import ppu_defines::*;

  always_comb begin
    rgb = BLACK;
    case (idx)
      6'h00: rgb = 24'h545454;  6'h01: rgb = 24'h001E74;
      6'h02: rgb = 24'h081090;  6'h03: rgb = 24'h300088;
      6'h04: rgb = 24'h440064;  6'h05: rgb = 24'h5C0030;
      6'h06: rgb = 24'h540400;  6'h07: rgb = 24'h3C1800;
      6'h08: rgb = 24'h202A00;  6'h09: rgb = 24'h083A00;
      6'h0A: rgb = 24'h004000;  6'h0B: rgb = 24'h003C00;
      6'h0C: rgb = 24'h00323C;
      6'h10: rgb = 24'h989698;  6'h11: rgb = 24'h084CC4;
      6'h12: rgb = 24'h3032EC;  6'h13: rgb = 24'h5C1EE4;
      6'h14: rgb = 24'h8814B0;  6'h15: rgb = 24'hA01464;
      6'h16: rgb = 24'h982220;  6'h17: rgb = 24'h783C00;
      6'h18: rgb = 24'h545A00;  6'h19: rgb = 24'h287200;
      6'h1A: rgb = 24'h087C00;  6'h1B: rgb = 24'h007628;
      6'h1C: rgb = 24'h006678;
      6'h20: rgb = 24'hECEEEC;  6'h21: rgb = 24'h4C9AEC;
      6'h22: rgb = 24'h787CEC;  6'h23: rgb = 24'hB062EC;
      6'h24: rgb = 24'hE454EC;  6'h25: rgb = 24'hEC58B4;
      6'h26: rgb = 24'hEC6A64;  6'h27: rgb = 24'hD48820;
      6'h28: rgb = 24'hA0AA00;  6'h29: rgb = 24'h74C400;
      6'h2A: rgb = 24'h4CD020;  6'h2B: rgb = 24'h38CC6C;
      6'h2C: rgb = 24'h38B4CC;  6'h2D: rgb = 24'h3C3C3C;
      6'h30: rgb = 24'hECEEEC;  6'h31: rgb = 24'hA8CCEC;
      6'h32: rgb = 24'hBCBCEC;  6'h33: rgb = 24'hD4B2EC;
      6'h34: rgb = 24'hECAEEC;  6'h35: rgb = 24'hECAED4;
      6'h36: rgb = 24'hECB4B0;  6'h37: rgb = 24'hE4C490;
      6'h38: rgb = 24'hCCD278;  6'h39: rgb = 24'hB4DE78;
      6'h3A: rgb = 24'hA8E290;  6'h3B: rgb = 24'h98E2B4;
      6'h3C: rgb = 24'hA0D6E4;  6'h3D: rgb = 24'hA0A2A0;
      default: rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/vga_scaled_out.sv
// vga_scaled_out: parametrised VGA output stage for the PPU.
// Generates programmable H/V timing, reads the scanline buffer, scales by
// integer (power-of-2) factors, maps NES indices to RGB and requests lines.
//   clk, rst_n        : clock, synchronous active-low reset
//   clk_en            : pixel-clock enable, all state advances only when high
//   crt_mode          : blank every replicated row except the first
//   vga_buf_idx       : scanline buffer read address (data one tick later)
//   vga_buf_out       : scanline buffer data
//   line_req/line_idx : one-tick request for the PPU to render line_idx
//   frame_start       : one-tick strobe when leaving row 0, col 0
//   hsync_n, vsync_n  : active-low syncs (delayed to match colour)
//   blank_n           : 0 outside active video
//   vga_r/g/b         : registered pixel colour
module vga_scaled_out #(
  parameter int unsigned H_VIS   = ppu_defines::DEF_H_VIS,
  parameter int unsigned H_FP    = ppu_defines::DEF_H_FP,
  parameter int unsigned H_SYNC  = ppu_defines::DEF_H_SYNC,
  parameter int unsigned H_BP    = ppu_defines::DEF_H_BP,
  parameter int unsigned H_IDLE  = ppu_defines::DEF_H_IDLE,
  parameter int unsigned V_PRE   = ppu_defines::DEF_V_PRE,
  parameter int unsigned V_VIS   = ppu_defines::DEF_V_VIS,
  parameter int unsigned V_FP    = ppu_defines::DEF_V_FP,
  parameter int unsigned V_SYNC  = ppu_defines::DEF_V_SYNC,
  parameter int unsigned V_BP    = ppu_defines::DEF_V_BP,
  parameter int unsigned H_SCALE = ppu_defines::DEF_H_SCALE,
  parameter int unsigned V_SCALE = ppu_defines::DEF_V_SCALE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       crt_mode,
  output logic [7:0] vga_buf_idx,
  input  logic [5:0] vga_buf_out,
  output logic       line_req,
  output logic [7:0] line_idx,
  output logic       frame_start,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP + H_IDLE;
  localparam int unsigned V_TOTAL = V_PRE + V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SHIFT = $clog2(H_SCALE);
  localparam int unsigned V_SHIFT = $clog2(V_SCALE);

  // Last column / row of each phase.
  localparam logic [9:0] H_END_VIS  = 10'(H_VIS - 1);
  localparam logic [9:0] H_END_FP   = 10'(H_VIS + H_FP - 1);
  localparam logic [9:0] H_END_SYNC = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_END_BP   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END_PRE  = 10'(V_PRE - 1);
  localparam logic [9:0] V_END_VIS  = 10'(V_PRE + V_VIS - 1);
  localparam logic [9:0] V_END_FP   = 10'(V_PRE + V_VIS + V_FP - 1);
  localparam logic [9:0] V_END_SYNC = 10'(V_PRE + V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  localparam logic [9:0] REQ_COL   = 10'(H_VIS);
  localparam logic [9:0] VIS_FIRST = 10'(V_PRE);
  localparam logic [9:0] VIS_END   = 10'(V_PRE + V_VIS);
  localparam logic [9:0] SUB_MASK  = 10'(V_SCALE - 1);

  logic [9:0] col, row;
  ppu_defines::vga_h_state_t h_state, h_next;
  ppu_defines::vga_v_state_t v_state, v_next;
  logic col_wrap;

  assign col_wrap    = (col == H_LAST);
  assign vga_buf_idx = 8'(col >> H_SHIFT);

  // Counters and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      h_state <= ppu_defines::H_VIS;
      v_state <= ppu_defines::V_PRE;
    end else if (clk_en) begin
      col     <= col_wrap ? '0 : col + 10'd1;
      if (col_wrap) row <= (row == V_LAST) ? '0 : row + 10'd1;
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Each state is left on the last column/row of its phase, so the state
  // always names the phase of the position currently held in col/row.
  always_comb begin
    h_next = h_state;
    case (h_state)
      ppu_defines::H_VIS:  if (col == H_END_VIS)  h_next = ppu_defines::H_FP;
      ppu_defines::H_FP:   if (col == H_END_FP)   h_next = ppu_defines::H_SYNC;
      ppu_defines::H_SYNC: if (col == H_END_SYNC) h_next = ppu_defines::H_BP;
      ppu_defines::H_BP:   if (col == H_END_BP)   h_next = ppu_defines::H_IDLE;
      ppu_defines::H_IDLE: if (col_wrap)          h_next = ppu_defines::H_VIS;
      default:                                    h_next = ppu_defines::H_VIS;
    endcase
  end

  always_comb begin
    v_next = v_state;
    if (col_wrap) begin
      case (v_state)
        ppu_defines::V_PRE:  if (row == V_END_PRE)  v_next = ppu_defines::V_VIS;
        ppu_defines::V_VIS:  if (row == V_END_VIS)  v_next = ppu_defines::V_FP;
        ppu_defines::V_FP:   if (row == V_END_FP)   v_next = ppu_defines::V_SYNC;
        ppu_defines::V_SYNC: if (row == V_END_SYNC) v_next = ppu_defines::V_BP;
        ppu_defines::V_BP:   if (row == V_LAST)     v_next = ppu_defines::V_PRE;
        default:                                    v_next = ppu_defines::V_PRE;
      endcase
    end
  end

  // Raw (undelayed) video qualifiers for the current position
  logic       raw_hs_n, raw_vs_n, raw_active, raw_black;
  logic [9:0] vis_off, nxt_row, nxt_off;
  logic       req_hit, frame_hit;
  logic [7:0] req_idx;

  always_comb begin
    raw_hs_n   = (h_state != ppu_defines::H_SYNC);
    raw_vs_n   = (v_state != ppu_defines::V_SYNC);
    raw_active = (h_state == ppu_defines::H_VIS) && (v_state == ppu_defines::V_VIS);
    vis_off    = row - VIS_FIRST;
    raw_black  = crt_mode && ((vis_off & SUB_MASK) != '0);
    // Request the source line feeding the next row when that row is the
    // first replica of a source line.
    nxt_row    = row + 10'd1;
    nxt_off    = nxt_row - VIS_FIRST;
    req_hit    = (col == REQ_COL) && (nxt_row >= VIS_FIRST) && (nxt_row < VIS_END) &&
                 ((nxt_off & SUB_MASK) == '0);
    req_idx    = 8'(nxt_off >> V_SHIFT);
    frame_hit  = (col == '0) && (row == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_req    <= 1'b0;
      line_idx    <= '0;
      frame_start <= 1'b0;
    end else if (clk_en) begin
      line_req    <= req_hit;
      frame_start <= frame_hit;
      if (req_hit) line_idx <= req_idx;
    end
  end

  // Two-stage output pipeline: stage 1 waits for buffer data, stage 2
  // registers colour together with the matching sync/blank.
  logic        s1_hs_n, s1_vs_n, s1_active, s1_black;
  logic [23:0] pal_rgb;

  nes_palette u_palette (
    .idx (vga_buf_out),
    .rgb (pal_rgb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hs_n   <= 1'b1;
      s1_vs_n   <= 1'b1;
      s1_active <= 1'b0;
      s1_black  <= 1'b0;
      hsync_n   <= 1'b1;
      vsync_n   <= 1'b1;
      blank_n   <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (clk_en) begin
      s1_hs_n   <= raw_hs_n;
      s1_vs_n   <= raw_vs_n;
      s1_active <= raw_active;
      s1_black  <= raw_black;
      hsync_n   <= s1_hs_n;
      vsync_n   <= s1_vs_n;
      blank_n   <= s1_active;
      {vga_r, vga_g, vga_b} <= (s1_active && !s1_black) ? pal_rgb : '0;
    end
  end

endmodule
